clk_div_n_50dc: RTL

Programmable integer clock divider that produces a 50 %-duty `clk_out` for any even or odd divisor N from 2 to 2^WIDTH−1. It is the parametrised successor of the fixed divide-by-3 50 %-duty counter. It adds a runtime-loadable divisor with glitch-free switching at period boundaries, an enable with clean park/restart, a wrap tick and an error flag. It sits in the clock-generation area and feeds derived-clock or strobe consumers from the single system clock.

---
 rtl/clk_div_n_50dc.sv | 117 +++++++++++
 1 files changed

// File: rtl/clk_div_n_50dc.sv
// Programmable 50%-duty integer clock divider, N = 2 .. 2^WIDTH-1,
// with a divisor that switches only at period boundaries.
//
// Ports:
//   clk        system clock (posedge logic, plus one negedge flop)
//   reset_L    synchronous active-low reset
//   en         run enable, honoured only at period boundaries
//   load       one-cycle strobe requesting div_in as the new divisor
//   div_in     requested divisor, rejected when below 2
//   clk_out    divided clock, 50% duty for both even and odd N
//   count_out  phase count within the current period, 0..N-1
//   tick       high in the last cycle of each running period
//   div_active divisor currently in effect
//   pending    an accepted divisor waits for the next boundary
//   err        one-cycle pulse after a rejected load
module clk_div_n_50dc #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   output logic             clk_out,
   output logic [WIDTH-1:0] count_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_active,
   output logic             pending,
   output logic             err
);

   localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

   typedef enum logic {
      S_RUN    = 1'b0,
      S_PARKED = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] div_pend;
   logic             hi_p;
   logic             hi_n;

   logic [WIDTH-1:0] last;
   logic [WIDTH-1:0] div_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] k_next;
   logic             ld_ok;
   logic             wrap;
   logic             boundary;
   logic             run_next;
   logic             hi_next;

   always_comb begin
      last     = div_active - WIDTH'(1);
      ld_ok    = load && (div_in >= WIDTH'(2));
      wrap     = (state == S_RUN) && (count == last);
      boundary = (state == S_PARKED) || wrap;

      div_next = div_active;
      if (boundary) begin
         if (ld_ok)
            div_next = div_in;
         else if (pending)
            div_next = div_pend;
      end

      count_next = boundary ? '0 : count + WIDTH'(1);
      run_next   = boundary ? en : 1'b1;

      // High phase length: H for even N, H+1 for odd N. It is taken
      // from the divisor that governs the next cycle so the high
      // phase tracks a divisor switch from its very first cycle.
      k_next  = (div_next >> 1) + WIDTH'(div_next[0]);
      hi_next = run_next && (count_next < k_next);
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state      <= S_PARKED;
         count      <= '0;
         div_active <= DEF;
         div_pend   <= DEF;
         pending    <= 1'b0;
         hi_p       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= run_next ? S_RUN : S_PARKED;
         count      <= count_next;
         div_active <= div_next;
         hi_p       <= hi_next;
         err        <= load && !ld_ok;
         if (boundary) begin
            pending <= 1'b0;
         end else if (ld_ok) begin
            div_pend <= div_in;
            pending  <= 1'b1;
         end
      end
   end

   // Half-cycle delayed copy of hi_p; ANDed in for odd N to trim
   // the extra high cycle down to a half cycle.
   always_ff @(negedge clk) begin
      if (!reset_L)
         hi_n <= 1'b0;
      else
         hi_n <= hi_p;
   end

   assign clk_out   = div_active[0] ? (hi_p & hi_n) : hi_p;
   assign count_out = count;
   assign tick      = (state == S_RUN) && (count == last);

endmodule
